line_mem_arbiter: RTL and testbench
===================================

// Module: line_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency line memory (64-bit line = 4 x 16-bit words) between the I-cache and D-cache miss paths.
//  Grants one line transaction at a time, round-robin on ties. Holds the memory command stable for the full access and returns the line with a 1-cycle done pulse.
//  Sits between the two cache controllers and the memory model.
// PARAMETERS
//  ADDR_W       16  word-address width
//  LINE_W       64  line width (bits)
//  LINE_WORDS    4  words per line; address low log2(LINE_WORDS) bits forced to 0
//  MEM_LATENCY   4  edges from memory sampling readM/writeM until FETCH3/STORE3
// PORTS
//  clk        in     1       clock, rising edge
//  reset_n    in     1       asynchronous, active-low reset
//  i_req      in     1       I-side line read request; held until i_done
//  i_addr     in     ADDR_W  I-side word address
//  i_rdata    out    LINE_W  I-side returned line; valid while i_done=1
//  i_done     out    1       1-cycle completion pulse, I-side
//  d_req      in     1       D-side request; held until d_done
//  d_we       in     1       D-side 1=line write, 0=line read
//  d_addr     in     ADDR_W  D-side word address
//  d_wdata    in     LINE_W  D-side write line
//  d_rdata    out    LINE_W  D-side returned line; valid while d_done=1
//  d_done     out    1       1-cycle completion pulse, D-side
//  m_readM    out    1       memory read command
//  m_writeM   out    1       memory write command
//  m_address  out    ADDR_W  memory line address, aligned
//  m_data     inout  LINE_W  memory data bus; driven only while m_writeM=1, else 'z
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, last_grant=I; m_readM=m_writeM=0, m_address=0, m_data='z, i_done=d_done=0, i_rdata=d_rdata=0.
//  All outputs except m_data are registered.
//  States: IDLE, BUSY_I, BUSY_D.
//  IDLE:
//   - Eligible req = req & ~done (a requester whose done is high this cycle is masked).
//   - Only one eligible requester: grant it.
//   - Both eligible: grant the side != last_grant (so D wins the first tie after reset).
//   - At the grant edge: latch aligned address, d_we, d_wdata; assert m_readM (I, or D with we=0) or m_writeM (D with we=1); cnt<=0; last_grant<=granted side.
//  BUSY_x:
//   - cnt increments each edge; m_readM/m_writeM, m_address and m_data held constant.
//   - Edge where cnt==MEM_LATENCY: sample m_data into x_rdata (reads only; writes leave d_rdata unchanged).
//   - Same edge: drop m_readM/m_writeM, pulse x_done for exactly 1 cycle, return to IDLE.
//  Timing: grant edge to done-high = MEM_LATENCY+1 edges. A new grant is possible on the edge after done, giving 1 idle command cycle between transactions (the memory must see the command low at the RESET-state sample).
//  Requests arriving while BUSY wait; never preempted. Address/data changes on a waiting req are used as sampled at its grant edge.
//  d_done on a write means the line has been committed to memory.
//  Reset mid-transaction: abort immediately, no done pulse; the memory shares reset_n.
//  cnt width = clog2(MEM_LATENCY+1); it never wraps (cleared at each grant).
//  Grants to one requester are never back-to-back while the other requester is waiting.
// STRUCTURE
//  Shared header mem_defs.vh:
//   - WORD_SIZE, FETCH_SIZE, LINE_WORDS, MEM_LATENCY
//   - arbiter state encodings IDLE/BUSY_I/BUSY_D
//  Sub-module rr_arbiter2: combinational 2-way round-robin pick from (req_i, req_d, last_grant).
//  Remainder (FSM, counter, latches, tri-state) stays in line_mem_arbiter.
// TESTING (bench uses the standard memory model with its reset image)
//  1. i_req=1, i_addr=0x0025, d_req=0.
//     -> m_address=0x0024, m_readM=1 for 5 cycles.
//     -> i_done 1 cycle, i_rdata=64'h6200_f41c_6100_f01c.
//  2. i_req and d_req (read 0x0000) rise in the same cycle after reset.
//     -> D granted first, d_rdata=64'h0000_ffff_0001_9023.
//     -> I granted on the edge after d_done.
//  3. D write d_addr=0x00F0, d_wdata=64'h4444_3333_2222_1111, then D read 0x00F0.
//     -> d_done after write; read returns the same line; m_data 'z outside the write.
//  4. Both requesters held continuously for 6 transactions.
//     -> grants alternate D,I,D,I,D,I; each transaction done 5 edges after its grant.
//  5. reset_n low during cnt=2 of a read.
//     -> all outputs immediately at reset values, no done pulse.
//     -> after release, a fresh request completes normally.
//  6. Requester keeps req high during its done cycle.
//     -> no re-grant from that stale req; re-grant only if req is still high next cycle.

Source files
------------

// File: rtl/line_mem_arbiter_pkg.sv
// Shared definitions for the line memory arbiter: memory geometry, latency,
// arbiter state encodings and the line-alignment helper.
package line_mem_arbiter_pkg;

    localparam int ADDR_W      = 16;
    localparam int WORD_SIZE   = 16;
    localparam int LINE_WORDS  = 4;
    localparam int LINE_W      = WORD_SIZE * LINE_WORDS;
    localparam int FETCH_SIZE  = LINE_W;
    localparam int MEM_LATENCY = 4;
    localparam int OFFSET_W    = $clog2(LINE_WORDS);
    localparam int CNT_W       = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbState_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grantSide_t;

    // Clears the word-offset bits so the memory always sees a line address.
    function automatic logic [ADDR_W-1:0] alignLine(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/line_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between the I-side and D-side requesters.
// On a tie the side that was not granted last wins.
module rr_arbiter2
    import line_mem_arbiter_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  grantSide_t last_grant,
    output logic       grantValid,
    output grantSide_t grantSide
);

    // Combinational winner selection
    always_comb begin
        grantValid = req_i | req_d;
        grantSide  = GRANT_I;
        if (req_i && req_d) begin
            grantSide = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (req_d) begin
            grantSide = GRANT_D;
        end else begin
            grantSide = GRANT_I;
        end
    end

endmodule

// File: rtl/line_mem_arbiter.sv
// Arbitrates one single-port fixed-latency line memory between the I-cache and
// D-cache miss paths; one transaction at a time, command held for the whole access.
module line_mem_arbiter
    import line_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_done,
    output logic              m_readM,
    output logic              m_writeM,
    output logic [ADDR_W-1:0] m_address,
    inout  wire  [LINE_W-1:0] m_data
);

    arbState_t         state,     stateNext;
    logic [CNT_W-1:0]  cnt,       cntNext;
    grantSide_t        lastGrant, lastGrantNext;
    logic              readR,     readNext;
    logic              writeR,    writeNext;
    logic [ADDR_W-1:0] addrR,     addrNext;
    logic [LINE_W-1:0] wdataR,    wdataNext;
    logic [LINE_W-1:0] iRdataR,   iRdataNext;
    logic [LINE_W-1:0] dRdataR,   dRdataNext;
    logic              iDoneR,    iDoneNext;
    logic              dDoneR,    dDoneNext;

    logic              reqIElig;
    logic              reqDElig;
    logic              grantValid;
    grantSide_t        grantSide;
    logic              accessEnd;

    // A requester in its done cycle still shows the old req; mask it so it is not re-granted.
    assign reqIElig  = i_req & ~iDoneR;
    assign reqDElig  = d_req & ~dDoneR;
    assign accessEnd = (cnt == CNT_W'(MEM_LATENCY));

    rr_arbiter2 uRrArbiter (
        .req_i      (reqIElig),
        .req_d      (reqDElig),
        .last_grant (lastGrant),
        .grantValid (grantValid),
        .grantSide  (grantSide)
    );

    // Next-state, command and completion logic
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        lastGrantNext = lastGrant;
        readNext      = readR;
        writeNext     = writeR;
        addrNext      = addrR;
        wdataNext     = wdataR;
        iRdataNext    = iRdataR;
        dRdataNext    = dRdataR;
        iDoneNext     = 1'b0;
        dDoneNext     = 1'b0;

        case (state)
            IDLE: begin
                if (grantValid) begin
                    cntNext       = {CNT_W{1'b0}};
                    lastGrantNext = grantSide;
                    if (grantSide == GRANT_D) begin
                        stateNext = BUSY_D;
                        addrNext  = alignLine(d_addr);
                        wdataNext = d_wdata;
                        readNext  = ~d_we;
                        writeNext = d_we;
                    end else begin
                        stateNext = BUSY_I;
                        addrNext  = alignLine(i_addr);
                        readNext  = 1'b1;
                        writeNext = 1'b0;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                cntNext = cnt + CNT_W'(1);
                if (accessEnd) begin
                    stateNext = IDLE;
                    readNext  = 1'b0;
                    writeNext = 1'b0;
                    if (state == BUSY_I) begin
                        iDoneNext  = 1'b1;
                        iRdataNext = m_data;
                    end else begin
                        dDoneNext = 1'b1;
                        // A write completion leaves the last read line visible.
                        if (readR) begin
                            dRdataNext = m_data;
                        end else begin
                            dRdataNext = dRdataR;
                        end
                    end
                end else begin
                    stateNext = state;
                end
            end
            default: begin
                stateNext = IDLE;
                readNext  = 1'b0;
                writeNext = 1'b0;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= {CNT_W{1'b0}};
            lastGrant <= GRANT_I;
            readR     <= 1'b0;
            writeR    <= 1'b0;
            addrR     <= {ADDR_W{1'b0}};
            wdataR    <= {LINE_W{1'b0}};
            iRdataR   <= {LINE_W{1'b0}};
            dRdataR   <= {LINE_W{1'b0}};
            iDoneR    <= 1'b0;
            dDoneR    <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            lastGrant <= lastGrantNext;
            readR     <= readNext;
            writeR    <= writeNext;
            addrR     <= addrNext;
            wdataR    <= wdataNext;
            iRdataR   <= iRdataNext;
            dRdataR   <= dRdataNext;
            iDoneR    <= iDoneNext;
            dDoneR    <= dDoneNext;
        end
    end

    assign m_readM   = readR;
    assign m_writeM  = writeR;
    assign m_address = addrR;
    assign i_rdata   = iRdataR;
    assign d_rdata   = dRdataR;
    assign i_done    = iDoneR;
    assign d_done    = dDoneR;
    assign m_data    = writeR ? wdataR : {LINE_W{1'bz}};

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Scoreboard bench for line_mem_arbiter with a fixed-latency line memory model.
module tb_line_mem_arbiter;

    localparam int LAT = 4;

    typedef struct {
        bit          side;   // 0 = I, 1 = D
        bit          we;
        logic [15:0] addr;
        logic [63:0] data;   // write line or expected read line
        logic [63:0] rdExp;  // expected x_rdata at done
        int          gap;    // expected idle command cycles before grant, -1 = any
    } txn_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr;
    logic [63:0] d_wdata;
    logic [63:0] i_rdata, d_rdata;
    logic        i_done, d_done, m_readM, m_writeM;
    logic [15:0] m_address;
    wire  [63:0] m_data;

    logic [63:0] memArr [0:16383];
    logic [63:0] refMem [0:16383];
    int          memCnt;
    logic        memDrive;

    txn_t        expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          doneTotal = 0;
    int          cmdCycles = 0;
    int          lowCycles = 0;
    bit          prevCmd = 0, prevIDone = 0, prevDDone = 0;
    logic [63:0] dLastExp = 64'h0;

    always #5 clk = ~clk;

    line_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_data(m_data)
    );

    function automatic logic [63:0] img(input int k);
        logic [15:0] kk;
        kk = 16'(k);
        if (k == 0) return 64'h0000_ffff_0001_9023;
        if (k == 9) return 64'h6200_f41c_6100_f01c;
        return {kk, 16'hC0DE, ~kk, 16'(k * 7)};
    endfunction

    // Memory model: counts edges with a command high, returns data / commits at LAT.
    assign memDrive = m_readM && (memCnt == LAT);
    assign m_data   = memDrive ? memArr[m_address[15:2]] : 64'bz;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            memCnt <= 0;
        end else if (m_readM || m_writeM) begin
            if (memCnt < LAT) memCnt <= memCnt + 1;
            else if (m_writeM) memArr[m_address[15:2]] <= m_data;
        end else begin
            memCnt <= 0;
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h, required %h", tag, got, exp);
        end
    endtask

    task automatic pushTxn(input bit side, input bit we, input logic [15:0] addr,
                           input logic [63:0] wdata, input int gap);
        txn_t t;
        logic [13:0] line;
        line   = addr[15:2];
        t.side = side;
        t.we   = we;
        t.addr = addr & 16'hFFFC;
        t.gap  = gap;
        if (we) begin
            refMem[line] = wdata;
            t.data  = wdata;
            t.rdExp = dLastExp;
        end else begin
            t.data  = refMem[line];
            t.rdExp = refMem[line];
            if (side) dLastExp = refMem[line];
        end
        expQ.push_back(t);
    endtask

    task automatic waitDones(input int target, input string tag);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (doneTotal >= target) return;
        end
        checkVal({tag, "_timeout"}, 64'(doneTotal), 64'(target));
    endtask

    // Monitor: grant checks on command rise, completion checks on done.
    always @(negedge clk) begin
        txn_t cur;
        bit   cmd;
        if (!reset_n) begin
            prevCmd = 0; cmdCycles = 0; lowCycles = 0; prevIDone = 0; prevDDone = 0;
        end else begin
            cmd = m_readM | m_writeM;
            if (cmd && !prevCmd) begin
                if (expQ.size() == 0) begin
                    checkVal("unexpected_grant", 64'(1), 64'(0));
                end else begin
                    cur = expQ[0];
                    checkVal("grant_addr", 64'(m_address), 64'(cur.addr));
                    checkVal("grant_cmd", {62'h0, m_readM, m_writeM}, {62'h0, ~cur.we, cur.we});
                    if (cur.gap >= 0) checkVal("grant_gap", 64'(lowCycles), 64'(cur.gap));
                    if (cur.we) checkVal("write_bus", m_data, cur.data);
                end
                cmdCycles = 0;
            end
            if (cmd) begin
                cmdCycles++;
                lowCycles = 0;
            end else begin
                lowCycles++;
            end
            if (i_done || d_done) begin
                doneTotal++;
                if (expQ.size() == 0) begin
                    checkVal("unexpected_done", 64'(1), 64'(0));
                end else begin
                    cur = expQ.pop_front();
                    checkVal("done_side", {62'h0, i_done, d_done}, cur.side ? 64'h1 : 64'h2);
                    checkVal("cmd_cycles", 64'(cmdCycles), 64'(LAT + 1));
                    checkVal("rdata", cur.side ? d_rdata : i_rdata, cur.rdExp);
                end
            end
            if (prevIDone) checkVal("i_done_pulse", 64'(i_done), 64'(0));
            if (prevDDone) checkVal("d_done_pulse", 64'(d_done), 64'(0));
            prevCmd = cmd; prevIDone = i_done; prevDDone = d_done;
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_readM"},   64'(m_readM),   64'(0));
        checkVal({tag, "_writeM"},  64'(m_writeM),  64'(0));
        checkVal({tag, "_address"}, 64'(m_address), 64'(0));
        checkVal({tag, "_dones"},   {62'h0, i_done, d_done}, 64'(0));
        checkVal({tag, "_i_rdata"}, i_rdata, 64'(0));
        checkVal({tag, "_d_rdata"}, d_rdata, 64'(0));
    endtask

    initial begin
        logic [15:0] aI [3];
        logic [15:0] aD [3];
        int          base;
        int          saved;
        bit          reached;

        for (int k = 0; k < 16384; k++) begin
            memArr[k] = img(k);
            refMem[k] = img(k);
        end
        reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 64'h0;
        repeat (3) @(negedge clk);
        #1 checkResetOutputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single I read of an unaligned address
        pushTxn(1'b0, 1'b0, 16'h0025, 64'h0, -1);
        #1 i_addr = 16'h0025; i_req = 1'b1;
        waitDones(1, "t1");
        i_req = 1'b0;
        repeat (3) @(negedge clk);

        // 2: simultaneous requests after reset, D wins, I follows with one idle cycle
        pushTxn(1'b1, 1'b0, 16'h0000, 64'h0, -1);
        pushTxn(1'b0, 1'b0, 16'h0046, 64'h0, 1);
        #1 d_addr = 16'h0000; d_we = 1'b0; d_req = 1'b1;
        i_addr = 16'h0046; i_req = 1'b1;
        waitDones(2, "t2a");
        d_req = 1'b0;
        waitDones(3, "t2b");
        i_req = 1'b0;
        repeat (3) @(negedge clk);

        // 4: both held for six transactions, strict alternation starting with D
        aD = '{16'h0100, 16'h0207, 16'h0312};
        aI = '{16'h1001, 16'h1103, 16'h1200};
        base = doneTotal;
        for (int k = 0; k < 3; k++) begin
            pushTxn(1'b1, 1'b0, aD[k], 64'h0, (k == 0) ? -1 : 1);
            pushTxn(1'b0, 1'b0, aI[k], 64'h0, 1);
        end
        #1 d_addr = aD[0]; i_addr = aI[0]; d_req = 1'b1; i_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            waitDones(base + k + 1, "t4");
            if (k == 4) d_req = 1'b0;
            else if (k == 5) i_req = 1'b0;
            else if (k % 2 == 0) d_addr = aD[k / 2 + 1];
            else i_addr = aI[k / 2 + 1];
        end
        repeat (3) @(negedge clk);

        // 3: D write then read-back of the same line
        base = doneTotal;
        pushTxn(1'b1, 1'b1, 16'h00F0, 64'h4444_3333_2222_1111, -1);
        pushTxn(1'b1, 1'b0, 16'h00F0, 64'h0, 2);
        #1 d_addr = 16'h00F0; d_we = 1'b1; d_wdata = 64'h4444_3333_2222_1111; d_req = 1'b1;
        waitDones(base + 1, "t3w");
        d_we = 1'b0; d_wdata = 64'h0;
        waitDones(base + 2, "t3r");
        d_req = 1'b0;
        repeat (3) @(negedge clk);

        // 6: req held through done; re-grant only after the masked cycle
        base = doneTotal;
        pushTxn(1'b0, 1'b0, 16'h0033, 64'h0, -1);
        pushTxn(1'b0, 1'b0, 16'h0080, 64'h0, 2);
        #1 i_addr = 16'h0033; i_req = 1'b1;
        waitDones(base + 1, "t6a");
        i_addr = 16'h0080;
        waitDones(base + 2, "t6b");
        i_req = 1'b0;
        repeat (3) @(negedge clk);

        // 5: reset while cnt == 2 of an I read
        pushTxn(1'b0, 1'b0, 16'h0050, 64'h0, -1);
        #1 i_addr = 16'h0050; i_req = 1'b1;
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            @(negedge clk); #1;
            if (m_readM && cmdCycles == 3) reached = 1'b1;
        end
        checkVal("t5_reach_cnt2", 64'(reached), 64'(1));
        reset_n = 1'b0;
        expQ.delete();
        dLastExp = 64'h0;
        i_req = 1'b0;
        saved = doneTotal;
        #1 checkResetOutputs("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        #1 checkVal("t5_no_done", 64'(doneTotal), 64'(saved));
        pushTxn(1'b1, 1'b0, 16'h000A, 64'h0, -1);
        d_addr = 16'h000A; d_we = 1'b0; d_req = 1'b1;
        waitDones(saved + 1, "t5_fresh");
        d_req = 1'b0;
        repeat (3) @(negedge clk);

        checkVal("queue_empty", 64'(expQ.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
